// File: rtl/riscv_register_file_mp_if.sv
// Bundle of read, write and reservation signals for riscv_register_file_mp.
// The decode/writeback side drives through master; the register file uses slave.
interface riscv_register_file_mp_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RPORTS = 3,
    parameter int NUM_WPORTS = 2,
    parameter int FPU        = 0
);
    localparam int AW = ADDR_WIDTH + FPU;

    logic [NUM_RPORTS*AW-1:0]         raddr_i;
    logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o;
    logic [NUM_RPORTS-1:0]            rbusy_o;
    logic [NUM_WPORTS*AW-1:0]         waddr_i;
    logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_WPORTS-1:0]            we_i;
    logic                             rsv_valid_i;
    logic [AW-1:0]                    rsv_addr_i;
    logic                             rsv_ready_o;
    logic                             flush_i;
    logic [AW:0]                      busy_cnt_o;

    modport master (
        output raddr_i, waddr_i, wdata_i, we_i,
        output rsv_valid_i, rsv_addr_i, flush_i,
        input  rdata_o, rbusy_o, rsv_ready_o, busy_cnt_o
    );

    modport slave (
        input  raddr_i, waddr_i, wdata_i, we_i,
        input  rsv_valid_i, rsv_addr_i, flush_i,
        output rdata_o, rbusy_o, rsv_ready_o, busy_cnt_o
    );
endinterface

// File: rtl/riscv_register_file_mp.sv
// Multi-port integer/FP register file with a per-register write-pending
// scoreboard; decode reserves destinations, writeback releases them.
module riscv_register_file_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RPORTS = 3,
    parameter int NUM_WPORTS = 2,
    parameter int FPU        = 0,
    parameter int BYPASS     = 1
) (
    input logic clk,
    input logic rst,
    riscv_register_file_mp_if.slave rf
);
    localparam int AW   = ADDR_WIDTH + FPU;
    localparam int NREG = 2 ** AW;

    logic [DATA_WIDTH-1:0] mem [NREG];
    logic [NREG-1:0]       busy;
    logic [AW:0]           cnt;

    logic [NREG-1:0] clr;
    logic [NREG-1:0] busy_next;
    logic            set_any;
    logic [AW:0]     clr_cnt;
    logic [AW:0]     cnt_next;
    logic            ready;

    assign ready = !rf.flush_i && !busy[rf.rsv_addr_i];
    assign rf.rsv_ready_o = ready;
    assign rf.busy_cnt_o  = cnt;

    // Address 0 is the hardwired integer zero; it never holds data or busy.
    always_comb begin
        clr     = '0;
        clr_cnt = '0;
        set_any = rf.rsv_valid_i && ready && (rf.rsv_addr_i != '0);
        for (int k = 0; k < NUM_WPORTS; k++) begin
            if (rf.we_i[k] && (rf.waddr_i[k*AW +: AW] != '0))
                clr[rf.waddr_i[k*AW +: AW]] = 1'b1;
        end
        for (int r = 0; r < NREG; r++) begin
            if (clr[r] && busy[r])
                clr_cnt = clr_cnt + 1'b1;
        end
        busy_next = busy & ~clr;
        if (set_any)
            busy_next[rf.rsv_addr_i] = 1'b1;
        cnt_next = cnt + (AW+1)'(set_any) - clr_cnt;
        if (rf.flush_i) begin
            busy_next = '0;
            cnt_next  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++)
                mem[r] <= '0;
            busy <= '0;
            cnt  <= '0;
        end else begin
            // Later ports overwrite earlier ones: highest index wins.
            for (int k = 0; k < NUM_WPORTS; k++) begin
                if (rf.we_i[k] && (rf.waddr_i[k*AW +: AW] != '0))
                    mem[rf.waddr_i[k*AW +: AW]] <= rf.wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
            busy <= busy_next;
            cnt  <= cnt_next;
        end
    end

    logic [DATA_WIDTH-1:0] rd   [NUM_RPORTS];
    logic [NUM_RPORTS-1:0] rbsy;

    always_comb begin
        for (int p = 0; p < NUM_RPORTS; p++) begin
            rd[p]   = mem[rf.raddr_i[p*AW +: AW]];
            rbsy[p] = busy[rf.raddr_i[p*AW +: AW]];
            if (BYPASS != 0) begin
                for (int k = 0; k < NUM_WPORTS; k++) begin
                    if (rf.we_i[k] &&
                        (rf.waddr_i[k*AW +: AW] == rf.raddr_i[p*AW +: AW])) begin
                        rd[p]   = rf.wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                        rbsy[p] = 1'b0;
                    end
                end
            end
            if (rf.raddr_i[p*AW +: AW] == '0) begin
                rd[p]   = '0;
                rbsy[p] = 1'b0;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RPORTS; p++)
            rf.rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rd[p];
    end

    assign rf.rbusy_o = rbsy;
endmodule

// File: tb/tb_riscv_register_file_mp.sv
// Directed bench for riscv_register_file_mp with FP bank and bypass enabled.
// Inputs change 1ns after each rising edge; outputs are sampled 1ns later.
module tb_riscv_register_file_mp;
    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_RPORTS = 3;
    localparam int NUM_WPORTS = 2;
    localparam int FPU        = 1;
    localparam int BYPASS     = 1;
    localparam int AW         = ADDR_WIDTH + FPU;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    riscv_register_file_mp_if #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_RPORTS(NUM_RPORTS),
        .NUM_WPORTS(NUM_WPORTS),
        .FPU(FPU)
    ) bus ();

    riscv_register_file_mp #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_RPORTS(NUM_RPORTS),
        .NUM_WPORTS(NUM_WPORTS),
        .FPU(FPU),
        .BYPASS(BYPASS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rf(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_addr(input int p, input logic [AW-1:0] a);
        bus.raddr_i[p*AW +: AW] = a;
    endtask

    task automatic wr(input int k, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic en);
        bus.waddr_i[k*AW +: AW]                 = a;
        bus.wdata_i[k*DATA_WIDTH +: DATA_WIDTH] = d;
        bus.we_i[k]                             = en;
    endtask

    function automatic logic [31:0] rdat(input int p);
        return bus.rdata_o[p*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    function automatic logic [31:0] rbsy(input int p);
        return {31'b0, bus.rbusy_o[p]};
    endfunction

    function automatic logic [31:0] cnt();
        return {25'b0, bus.busy_cnt_o};
    endfunction

    function automatic logic [31:0] rdy();
        return {31'b0, bus.rsv_ready_o};
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.raddr_i     = '0;
        bus.waddr_i     = '0;
        bus.wdata_i     = '0;
        bus.we_i        = '0;
        bus.rsv_valid_i = 1'b0;
        bus.rsv_addr_i  = '0;
        bus.flush_i     = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        rd_addr(0, 6'd0);
        rd_addr(1, 6'd5);
        rd_addr(2, 6'd32);
        #1;
        chk("rst_rd0", rdat(0), 32'h0);
        chk("rst_rd1", rdat(1), 32'h0);
        chk("rst_rd2", rdat(2), 32'h0);
        chk("rst_busy", {29'b0, bus.rbusy_o}, 32'h0);
        chk("rst_ready", rdy(), 32'h1);
        chk("rst_cnt", cnt(), 32'h0);

        // same-address double write, port 1 wins
        tick();
        rd_addr(0, 6'd5);
        wr(0, 6'd5, 32'hDEADBEEF, 1'b1);
        wr(1, 6'd5, 32'h12345678, 1'b1);
        #1;
        chk("byp_hi_wins", rdat(0), 32'h12345678);
        tick();
        wr(0, 6'd0, 32'h0, 1'b0);
        wr(1, 6'd0, 32'h0, 1'b0);
        #1;
        chk("store_hi_wins", rdat(0), 32'h12345678);

        // x0 ignores writes, FP 0 is ordinary
        tick();
        rd_addr(1, 6'd0);
        rd_addr(2, 6'd32);
        wr(0, 6'd0, 32'hFFFFFFFF, 1'b1);
        wr(1, 6'd32, 32'hA5A5A5A5, 1'b1);
        #1;
        chk("x0_byp", rdat(1), 32'h0);
        chk("fp0_byp", rdat(2), 32'hA5A5A5A5);
        tick();
        wr(0, 6'd0, 32'h0, 1'b0);
        wr(1, 6'd0, 32'h0, 1'b0);
        #1;
        chk("x0_store", rdat(1), 32'h0);
        chk("fp0_store", rdat(2), 32'hA5A5A5A5);

        // reserve x7 then x9
        tick();
        bus.rsv_valid_i = 1'b1;
        bus.rsv_addr_i  = 6'd7;
        #1;
        chk("rsv7_ready", rdy(), 32'h1);
        tick();
        bus.rsv_addr_i = 6'd9;
        #1;
        chk("cnt_1", cnt(), 32'h1);
        tick();
        bus.rsv_valid_i = 1'b0;
        bus.rsv_addr_i  = 6'd7;
        rd_addr(0, 6'd7);
        rd_addr(1, 6'd9);
        #1;
        chk("cnt_2", cnt(), 32'h2);
        chk("x7_busy", rbsy(0), 32'h1);
        chk("x9_busy", rbsy(1), 32'h1);
        chk("x7_not_ready", rdy(), 32'h0);

        // release x7
        tick();
        wr(0, 6'd7, 32'h00000077, 1'b1);
        #1;
        chk("x7_byp_clear", rbsy(0), 32'h0);
        chk("x7_byp_data", rdat(0), 32'h00000077);
        tick();
        wr(0, 6'd0, 32'h0, 1'b0);
        #1;
        chk("cnt_after_wr", cnt(), 32'h1);
        chk("x7_free", rbsy(0), 32'h0);
        chk("x7_data", rdat(0), 32'h00000077);
        chk("x7_ready", rdy(), 32'h1);
        chk("x9_still", rbsy(1), 32'h1);

        // reserve and write x3 in the same cycle
        tick();
        bus.rsv_valid_i = 1'b1;
        bus.rsv_addr_i  = 6'd3;
        wr(0, 6'd3, 32'h00000055, 1'b1);
        rd_addr(2, 6'd3);
        tick();
        bus.rsv_valid_i = 1'b0;
        wr(0, 6'd0, 32'h0, 1'b0);
        #1;
        chk("x3_data", rdat(2), 32'h00000055);
        chk("x3_busy", rbsy(2), 32'h1);
        chk("cnt_x3", cnt(), 32'h2);

        // x0 reservation accepted but not counted
        tick();
        bus.rsv_valid_i = 1'b1;
        bus.rsv_addr_i  = 6'd0;
        #1;
        chk("x0_rsv_ready", rdy(), 32'h1);
        tick();
        bus.rsv_valid_i = 1'b0;
        #1;
        chk("x0_rsv_cnt", cnt(), 32'h2);

        // reserve x1, x2, x4 then flush
        tick();
        bus.rsv_valid_i = 1'b1;
        bus.rsv_addr_i  = 6'd1;
        tick();
        bus.rsv_addr_i = 6'd2;
        tick();
        bus.rsv_addr_i = 6'd4;
        tick();
        bus.rsv_valid_i = 1'b0;
        #1;
        chk("cnt_5", cnt(), 32'h5);
        tick();
        bus.flush_i     = 1'b1;
        bus.rsv_valid_i = 1'b1;
        bus.rsv_addr_i  = 6'd6;
        #1;
        chk("flush_not_ready", rdy(), 32'h0);
        tick();
        bus.flush_i     = 1'b0;
        bus.rsv_valid_i = 1'b0;
        rd_addr(0, 6'd6);
        rd_addr(1, 6'd3);
        rd_addr(2, 6'd9);
        #1;
        chk("flush_cnt", cnt(), 32'h0);
        chk("flush_x6", rbsy(0), 32'h0);
        chk("flush_x3", rbsy(1), 32'h0);
        chk("flush_x9", rbsy(2), 32'h0);
        chk("flush_keeps_data", rdat(1), 32'h00000055);

        // reset mid-sequence
        tick();
        bus.rsv_valid_i = 1'b1;
        bus.rsv_addr_i  = 6'd10;
        tick();
        bus.rsv_valid_i = 1'b0;
        wr(0, 6'd11, 32'h000000BB, 1'b1);
        tick();
        rd_addr(0, 6'd11);
        wr(0, 6'd0, 32'h0, 1'b0);
        #1;
        chk("pre_rst_cnt", cnt(), 32'h1);
        chk("pre_rst_x11", rdat(0), 32'h000000BB);
        rst = 1'b1;
        wr(0, 6'd12, 32'h000000CC, 1'b1);
        bus.rsv_valid_i = 1'b1;
        bus.rsv_addr_i  = 6'd13;
        tick();
        rst = 1'b0;
        wr(0, 6'd0, 32'h0, 1'b0);
        bus.rsv_valid_i = 1'b0;
        bus.rsv_addr_i  = 6'd10;
        rd_addr(0, 6'd11);
        rd_addr(1, 6'd5);
        rd_addr(2, 6'd32);
        #1;
        chk("rst2_cnt", cnt(), 32'h0);
        chk("rst2_x11", rdat(0), 32'h0);
        chk("rst2_x5", rdat(1), 32'h0);
        chk("rst2_fp0", rdat(2), 32'h0);
        chk("rst2_ready", rdy(), 32'h1);
        rd_addr(0, 6'd12);
        rd_addr(1, 6'd13);
        rd_addr(2, 6'd10);
        #1;
        chk("rst2_x12", rdat(0), 32'h0);
        chk("rst2_x13_busy", rbsy(1), 32'h0);
        chk("rst2_x10_busy", rbsy(2), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
